// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for shared_reg_arbiter.
// Holds the arbiter state enum, the write-counter width and its
// saturation value, and a saturating increment helper.
package shared_reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int         WR_COUNT_W   = 8;
    localparam logic [7:0] WR_COUNT_SAT = 8'hFF;

    function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
        return (v == WR_COUNT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   valid  in  NREQ   request vector
//   ptr    in  IDW    highest-priority index this cycle
//   grant  out NREQ   one-hot-or-zero grant
//   idx    out IDW    index of the granted requester (0 when none)
//   any    out 1      at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int cand;

    // Walk from ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter in front of one shared
// WIDTH-bit register (posedge, reset to INIT).
// Optional lock mode, enabled by defining SHARED_REG_ARB_LOCK_EN, lets a
// writer keep exclusive ownership; an idle owner is evicted after
// LOCK_TIMEOUT cycles and LOCK_ERR pulses for one cycle.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   REQ_VALID    per-requester write pending
//   REQ_DATA     requester i data at [i*WIDTH +: WIDTH]
//   REQ_LOCK     per-requester keep-ownership request
//   REQ_READY    one-hot-or-zero grant (combinational)
//   O            shared register value
//   LAST_ID      index of the most recent writer
//   WR_COUNT     accepted writes since reset, saturating at 8'hFF
//   LOCK_ERR     one-cycle pulse on lock timeout
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               NREQ         = 4,
    parameter logic [WIDTH-1:0] INIT         = '0,
    parameter int               LOCK_TIMEOUT = 16,
    parameter int               IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         REQ_VALID,
    input  logic [NREQ*WIDTH-1:0]   REQ_DATA,
    input  logic [NREQ-1:0]         REQ_LOCK,
    output logic [NREQ-1:0]         REQ_READY,
    output logic [WIDTH-1:0]        O,
    output logic [IDW-1:0]          LAST_ID,
    output logic [WR_COUNT_W-1:0]   WR_COUNT,
    output logic                    LOCK_ERR
);

    logic [WIDTH-1:0]      o_q, o_d;
    logic [IDW-1:0]        last_id_q, last_id_d;
    logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
    logic [IDW-1:0]        ptr_q, ptr_d;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [IDW-1:0]  xfer_idx;
    logic            xfer;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (REQ_VALID),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return IDW'((int'(i) + 1) % NREQ);
    endfunction

`ifdef SHARED_REG_ARB_LOCK_EN
    localparam logic [7:0] TMO_LAST = 8'(LOCK_TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [7:0]     tmo_q, tmo_d;
    logic           lock_err_q, lock_err_d;

    // While locked only the owner can be granted, and only if it is valid.
    always_comb begin
        REQ_READY = '0;
        xfer_idx  = pick_idx;
        if (state_q == LOCKED) begin
            REQ_READY[owner_q] = REQ_VALID[owner_q];
            xfer_idx           = owner_q;
        end else begin
            REQ_READY = pick_grant;
        end
    end

    assign xfer = |(REQ_VALID & REQ_READY);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        tmo_d      = tmo_q;
        lock_err_d = 1'b0;
        ptr_d      = xfer ? next_idx(xfer_idx) : ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer && REQ_LOCK[xfer_idx]) begin
                    state_d = LOCKED;
                    owner_d = xfer_idx;
                    tmo_d   = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    tmo_d = '0;
                    if (!REQ_LOCK[owner_q]) state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    // Evict the idle owner; arbitration resumes after it.
                    state_d    = IDLE;
                    tmo_d      = '0;
                    lock_err_d = 1'b1;
                    ptr_d      = next_idx(owner_q);
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            tmo_q      <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            tmo_q      <= tmo_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign LOCK_ERR = lock_err_q;
`else
    // Lock requests have no effect in this build.
    logic unused_lock;
    assign unused_lock = ^REQ_LOCK ^ pick_any;

    assign REQ_READY = pick_grant;
    assign xfer_idx  = pick_idx;
    assign xfer      = |(REQ_VALID & REQ_READY);
    assign LOCK_ERR  = 1'b0;

    always_comb begin
        ptr_d = xfer ? next_idx(xfer_idx) : ptr_q;
    end
`endif

    // Register data path: one write per cycle from the granted requester.
    always_comb begin
        o_d        = o_q;
        last_id_d  = last_id_q;
        wr_count_d = wr_count_q;
        if (xfer) begin
            o_d        = REQ_DATA[int'(xfer_idx)*WIDTH +: WIDTH];
            last_id_d  = xfer_idx;
            wr_count_d = sat_inc(wr_count_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_q        <= INIT;
            last_id_q  <= '0;
            wr_count_q <= '0;
            ptr_q      <= '0;
        end else begin
            o_q        <= o_d;
            last_id_q  <= last_id_d;
            wr_count_q <= wr_count_d;
            ptr_q      <= ptr_d;
        end
    end

    assign O        = o_q;
    assign LAST_ID  = last_id_q;
    assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (WIDTH=16, NREQ=4,
// LOCK_TIMEOUT=16). Lock scenarios run when SHARED_REG_ARB_LOCK_EN is
// defined; otherwise the bench checks that lock requests are ignored.
module tb_shared_reg_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      o;
    logic [1:0]            last_id;
    logic [7:0]            wr_count;
    logic                  lock_err;

    int n_chk  = 0;
    int n_fail = 0;

    shared_reg_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .INIT(16'h0000), .LOCK_TIMEOUT(16)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .REQ_VALID (req_valid),
        .REQ_DATA  (req_data),
        .REQ_LOCK  (req_lock),
        .REQ_READY (req_ready),
        .O         (o),
        .LAST_ID   (last_id),
        .WR_COUNT  (wr_count),
        .LOCK_ERR  (lock_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1ns after it; registered outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) set_data(i, 16'h00A0 + 16'(i));
        step();
        step();
        chk("rst_o", 32'(o), 32'h0000);
        chk("rst_last_id", 32'(last_id), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_lock_err", 32'(lock_err), 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_idle", 32'(req_ready), 0);

        // All valid: grants rotate 0,1,2,3.
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1 << k));
            step();
            chk("rr_o", 32'(o), 32'h00A0 + 32'(k));
            chk("rr_last_id", 32'(last_id), 32'(k));
            chk("rr_wr_count", 32'(wr_count), 32'(k + 1));
        end

        // Move pointer to 2, then wrap to requester 0.
        req_valid = 4'b0010;
        #1;
        chk("ptr_setup_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0011;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'b0001);
        step();
        chk("wrap_last_id", 32'(last_id), 0);
        chk("wrap_o", 32'(o), 32'h00A0);
        #1;
        chk("ptr1_ready", 32'(req_ready), 32'b0010);
        step();
        chk("b2b_last_id", 32'(last_id), 1);
        chk("b2b_wr_count", 32'(wr_count), 7);

        // Data changes alone never affect the grant; dropping valid costs nothing.
        set_data(2, 16'hFFFF);
        req_valid = 4'b0000;
        #1;
        chk("noreq_ready", 32'(req_ready), 0);
        step();
        chk("noreq_wr_count", 32'(wr_count), 7);
        set_data(2, 16'h00A2);

`ifdef SHARED_REG_ARB_LOCK_EN
        // Requester 1 locks with 1234.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        set_data(1, 16'h1234);
        #1;
        chk("lock_ready", 32'(req_ready), 32'b0010);
        step();
        chk("lock_o", 32'(o), 32'h1234);
        chk("lock_wr_count", 32'(wr_count), 8);
        req_valid = 4'b1101;
        #1;
        chk("locked_others_blocked", 32'(req_ready), 0);
        step();
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        set_data(1, 16'h5678);
        #1;
        chk("locked_owner_ready", 32'(req_ready), 32'b0010);
        step();
        chk("unlock_o", 32'(o), 32'h5678);
        chk("unlock_last_id", 32'(last_id), 1);
        #1;
        chk("after_unlock_ready", 32'(req_ready), 32'b0100);
        step();
        chk("after_unlock_wr_count", 32'(wr_count), 10);

        // Requester 3 locks, then goes idle until the timeout evicts it.
        req_valid = 4'b1000;
        req_lock  = 4'b1000;
        #1;
        chk("tmo_lock_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0111;
        req_lock  = 4'b0000;
        for (int c = 1; c < 16; c++) begin
            step();
            chk("tmo_no_err_yet", 32'(lock_err), 0);
            chk("tmo_still_locked", 32'(req_ready), 0);
        end
        step();
        chk("tmo_lock_err", 32'(lock_err), 1);
        chk("tmo_ready_req0", 32'(req_ready), 32'b0001);
        step();
        chk("tmo_err_clears", 32'(lock_err), 0);
        chk("tmo_last_id", 32'(last_id), 0);
        chk("tmo_wr_count", 32'(wr_count), 12);

        // Reset while locked with a transfer in flight.
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        step();
        chk("pre_rst_o", 32'(o), 32'h00A2);
        set_data(2, 16'hBEEF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midlock_rst_o", 32'(o), 32'h0000);
        chk("midlock_rst_wr_count", 32'(wr_count), 0);
        chk("midlock_rst_last_id", 32'(last_id), 0);
        req_valid = 4'b0011;
        req_lock  = 4'b0000;
        #1;
        chk("midlock_rst_idle", 32'(req_ready), 32'b0001);
`else
        // Lock request must not hold the grant.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        step();
        req_valid = 4'b0101;
        #1;
        chk("nolock_ready", 32'(req_ready), 32'b0100);
        req_valid = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("nolock_err", 32'(lock_err), 0);
        end
        req_valid = 4'b1111;
        set_data(0, 16'hBEEF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midxfer_rst_o", 32'(o), 32'h0000);
        chk("midxfer_rst_wr_count", 32'(wr_count), 0);
        #1;
        chk("midxfer_rst_ready", 32'(req_ready), 32'b0001);
        set_data(0, 16'h00A0);
`endif

        // Saturation: 300 back-to-back writes.
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (n == 254) chk("sat_fe", 32'(wr_count), 32'hFE);
            if (n == 255) chk("sat_ff", 32'(wr_count), 32'hFF);
        end
        chk("sat_hold", 32'(wr_count), 32'hFF);
        chk("sat_last_id", 32'(last_id), 32'((300 - 1) % 4));
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
